// File: rtl/stopwatch_pkg.sv
// Shared encodings, widths and full-scale defaults for the stopwatch controller.
package stopwatch_pkg;

    localparam int MS_W        = 10;
    localparam int SEC_W       = 6;
    localparam int MAX_MS_DEF  = 999;
    localparam int MAX_SEC_DEF = 59;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    // RUN and LAP both keep the counter advancing; LAP only freezes the display.
    function automatic logic is_counting(input state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced, already-synchronous button level.
module btn_edge (
    input  logic I_CLK,
    input  logic I_RST,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM: button events to counter enable/clear, lap-hold display and overflow stop.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_SEC = MAX_SEC_DEF,
    parameter int MAX_MS  = MAX_MS_DEF
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             I_BTN_SS,
    input  logic             I_BTN_LC,
    input  logic             I_EN_1MS,
    input  logic [MS_W-1:0]  I_TIMER_MS,
    input  logic [SEC_W-1:0] I_TIMER_SEC,
    output logic             O_START_EN,
    output logic             O_CLEAR_EN,
    output logic [MS_W-1:0]  O_DISP_MS,
    output logic [SEC_W-1:0] O_DISP_SEC,
    output logic [1:0]       O_STATE,
    output logic             O_OVF
);

    localparam logic [MS_W-1:0]  MAX_MS_L  = MS_W'(MAX_MS);
    localparam logic [SEC_W-1:0] MAX_SEC_L = SEC_W'(MAX_SEC);

    state_e           state_q, state_d;
    logic             start_q, start_d;
    logic             clear_q, clear_d;
    logic             ovf_q, ovf_d;
    logic [MS_W-1:0]  disp_ms_q, disp_ms_d;
    logic [SEC_W-1:0] disp_sec_q, disp_sec_d;

    logic ss_rise;
    logic lc_rise;
    logic full_scale;

    btn_edge u_ss_edge (
        .I_CLK  (I_CLK),
        .I_RST  (I_RST),
        .btn_i  (I_BTN_SS),
        .rise_o (ss_rise)
    );

    btn_edge u_lc_edge (
        .I_CLK  (I_CLK),
        .I_RST  (I_RST),
        .btn_i  (I_BTN_LC),
        .rise_o (lc_rise)
    );

    // Only meaningful while counting; the FSM gates it by state.
    assign full_scale = I_EN_1MS && (I_TIMER_SEC == MAX_SEC_L) && (I_TIMER_MS == MAX_MS_L);

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            ovf_q      <= 1'b0;
            disp_ms_q  <= '0;
            disp_sec_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            clear_q    <= clear_d;
            ovf_q      <= ovf_d;
            disp_ms_q  <= disp_ms_d;
            disp_sec_q <= disp_sec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clear_d    = 1'b0;
        ovf_d      = ovf_q;
        disp_ms_d  = I_TIMER_MS;
        disp_sec_d = I_TIMER_SEC;

        case (state_q)
            ST_IDLE: begin
                if (ss_rise) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (full_scale) begin
                    state_d = ST_STOP;
                    ovf_d   = 1'b1;
                end else if (ss_rise) begin
                    state_d = ST_STOP;
                end else if (lc_rise) begin
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (full_scale) begin
                    state_d = ST_STOP;
                    ovf_d   = 1'b1;
                end else if (ss_rise) begin
                    state_d = ST_STOP;
                end else if (lc_rise) begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                // After an overflow the watch can only be cleared, never restarted.
                if (ss_rise && !ovf_q) begin
                    state_d = ST_RUN;
                end else if (lc_rise) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_d = is_counting(state_d);

        // Entering LAP loads the live value once; it is then held until LAP is left.
        if ((state_q == ST_LAP) && (state_d == ST_LAP)) begin
            disp_ms_d  = disp_ms_q;
            disp_sec_d = disp_sec_q;
        end
    end

    assign O_START_EN = start_q;
    assign O_CLEAR_EN = clear_q;
    assign O_OVF      = ovf_q;
    assign O_DISP_MS  = disp_ms_q;
    assign O_DISP_SEC = disp_sec_q;
    assign O_STATE    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, corner sequences and a random run against a reference model.
module tb_stopwatch_ctrl;

    logic       I_CLK;
    logic       I_RST;
    logic       I_BTN_SS;
    logic       I_BTN_LC;
    logic       I_EN_1MS;
    logic [9:0] I_TIMER_MS;
    logic [5:0] I_TIMER_SEC;
    logic       O_START_EN;
    logic       O_CLEAR_EN;
    logic [9:0] O_DISP_MS;
    logic [5:0] O_DISP_SEC;
    logic [1:0] O_STATE;
    logic       O_OVF;

    int compared   = 0;
    int mismatched = 0;

    stopwatch_ctrl dut (
        .I_CLK       (I_CLK),
        .I_RST       (I_RST),
        .I_BTN_SS    (I_BTN_SS),
        .I_BTN_LC    (I_BTN_LC),
        .I_EN_1MS    (I_EN_1MS),
        .I_TIMER_MS  (I_TIMER_MS),
        .I_TIMER_SEC (I_TIMER_SEC),
        .O_START_EN  (O_START_EN),
        .O_CLEAR_EN  (O_CLEAR_EN),
        .O_DISP_MS   (O_DISP_MS),
        .O_DISP_SEC  (O_DISP_SEC),
        .O_STATE     (O_STATE),
        .O_OVF       (O_OVF)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    // Reference model: state as plain integers 0=IDLE 1=RUN 2=LAP 3=STOP.
    int mState, mMs, mSec;
    bit mPrevSs, mPrevLc, mStart, mClear, mOvf;

    task automatic modelStep(input bit rst, input bit ss, input bit lc, input bit en,
                             input int ms, input int sec);
        bit ssEv, lcEv, counting, ovfEv;
        int nxt;
        if (rst) begin
            mState = 0; mMs = 0; mSec = 0;
            mPrevSs = 0; mPrevLc = 0; mStart = 0; mClear = 0; mOvf = 0;
            return;
        end
        ssEv = ss && !mPrevSs;
        lcEv = lc && !mPrevLc;
        mPrevSs = ss;
        mPrevLc = lc;
        counting = (mState == 1) || (mState == 2);
        ovfEv = counting && en && (sec == 59) && (ms == 999);
        mClear = 0;
        nxt = mState;
        if (ovfEv) begin
            nxt = 3;
            mOvf = 1;
        end else if (mState == 0) begin
            if (ssEv) nxt = 1;
        end else if (counting) begin
            if (ssEv) nxt = 3;
            else if (lcEv) nxt = (mState == 1) ? 2 : 1;
        end else begin
            if (ssEv && !mOvf) nxt = 1;
            else if (lcEv) begin
                nxt = 0;
                mClear = 1;
                mOvf = 0;
            end
        end
        if (!(mState == 2 && nxt == 2)) begin
            mMs = ms;
            mSec = sec;
        end
        mState = nxt;
        mStart = (nxt == 1) || (nxt == 2);
    endtask

    task automatic applyStimulus(input bit rst, input bit ss, input bit lc, input bit en,
                                 input int ms, input int sec);
        @(negedge I_CLK);
        I_RST       = rst;
        I_BTN_SS    = ss;
        I_BTN_LC    = lc;
        I_EN_1MS    = en;
        I_TIMER_MS  = 10'(ms);
        I_TIMER_SEC = 6'(sec);
        @(posedge I_CLK);
        modelStep(rst, ss, lc, en, ms, sec);
        #1;
    endtask

    task automatic compareField(input string tag, input string field, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s.%s actual=%0d required=%0d", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int expState, input int expStart,
                               input int expClear, input int expOvf, input int expMs, input int expSec);
        compareField(tag, "state", int'(O_STATE), expState);
        compareField(tag, "start_en", int'(O_START_EN), expStart);
        compareField(tag, "clear_en", int'(O_CLEAR_EN), expClear);
        compareField(tag, "ovf", int'(O_OVF), expOvf);
        compareField(tag, "disp_ms", int'(O_DISP_MS), expMs);
        compareField(tag, "disp_sec", int'(O_DISP_SEC), expSec);
    endtask

    typedef struct {
        bit rst, ss, lc, en;
        int ms, sec;
        int st, start, clr, ovf, dms, dsec;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input bit rst, input bit ss, input bit lc, input bit en, input int ms,
                          input int sec, input int st, input int start, input int clr,
                          input int ovf, input int dms, input int dsec);
        vec_t v;
        v.rst = rst; v.ss = ss; v.lc = lc; v.en = en; v.ms = ms; v.sec = sec;
        v.st = st; v.start = start; v.clr = clr; v.ovf = ovf; v.dms = dms; v.dsec = dsec;
        vecs.push_back(v);
    endtask

    initial begin
        bit ss, lc, en, rst;
        int ms, sec;

        I_RST = 1'b1; I_BTN_SS = 1'b0; I_BTN_LC = 1'b0; I_EN_1MS = 1'b0;
        I_TIMER_MS = '0; I_TIMER_SEC = '0;

        //     rst ss lc en  ms  sec  st st_en clr ovf dms dsec
        addVec(1, 0, 0, 0,   0,  0,   0, 0, 0, 0,   0,  0);
        addVec(0, 0, 0, 0,   7,  0,   0, 0, 0, 0,   7,  0);
        addVec(0, 1, 0, 0,   8,  0,   1, 1, 0, 0,   8,  0);
        addVec(0, 1, 0, 0,   9,  0,   1, 1, 0, 0,   9,  0);
        addVec(0, 0, 1, 0, 250,  3,   2, 1, 0, 0, 250,  3);
        addVec(0, 0, 1, 0, 260,  3,   2, 1, 0, 0, 250,  3);
        addVec(0, 0, 0, 0, 300,  3,   2, 1, 0, 0, 250,  3);
        addVec(0, 0, 1, 0, 310,  3,   1, 1, 0, 0, 310,  3);
        addVec(0, 0, 0, 0, 320,  3,   1, 1, 0, 0, 320,  3);
        addVec(0, 1, 1, 0, 330,  3,   3, 0, 0, 0, 330,  3);
        addVec(0, 0, 0, 0, 330,  3,   3, 0, 0, 0, 330,  3);
        addVec(0, 1, 1, 0, 330,  3,   1, 1, 0, 0, 330,  3);
        addVec(0, 0, 0, 0, 330,  3,   1, 1, 0, 0, 330,  3);
        addVec(0, 1, 0, 0, 330,  3,   3, 0, 0, 0, 330,  3);
        addVec(0, 0, 1, 0, 330,  3,   0, 0, 1, 0, 330,  3);
        addVec(0, 0, 0, 0,   0,  0,   0, 0, 0, 0,   0,  0);
        addVec(0, 1, 0, 0,   0,  0,   1, 1, 0, 0,   0,  0);
        addVec(0, 0, 0, 1, 999, 59,   3, 0, 0, 1, 999, 59);
        addVec(0, 1, 0, 0, 999, 59,   3, 0, 0, 1, 999, 59);
        addVec(0, 0, 0, 0, 999, 59,   3, 0, 0, 1, 999, 59);
        addVec(0, 1, 1, 0, 999, 59,   0, 0, 1, 0, 999, 59);
        addVec(0, 0, 0, 0,   0,  0,   0, 0, 0, 0,   0,  0);
        addVec(0, 1, 0, 0,   0,  0,   1, 1, 0, 0,   0,  0);
        addVec(0, 0, 1, 0, 100,  2,   2, 1, 0, 0, 100,  2);
        addVec(0, 0, 0, 1, 999, 59,   3, 0, 0, 1, 999, 59);
        addVec(0, 0, 1, 0, 999, 59,   0, 0, 1, 0, 999, 59);
        addVec(0, 1, 0, 0,   5,  0,   1, 1, 0, 0,   5,  0);
        addVec(1, 0, 0, 0,   5,  0,   0, 0, 0, 0,   0,  0);
        addVec(0, 0, 0, 1, 999, 59,   0, 0, 0, 0, 999, 59);
        addVec(0, 1, 0, 0, 999, 59,   1, 1, 0, 0, 999, 59);
        addVec(0, 0, 0, 0, 999, 59,   1, 1, 0, 0, 999, 59);
        addVec(0, 0, 0, 1, 998, 59,   1, 1, 0, 0, 998, 59);
        addVec(0, 0, 0, 1, 999, 58,   1, 1, 0, 0, 999, 58);
        addVec(1, 0, 0, 0,   0,  0,   0, 0, 0, 0,   0,  0);

        $display("[TB] reset with buttons pressed");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 1, 1, 5, 1);
            checkOutput("reset", 0, 0, 0, 0, 0, 0);
        end

        $display("[TB] vector table, %0d rows", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ss, vecs[i].lc, vecs[i].en, vecs[i].ms, vecs[i].sec);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].start, vecs[i].clr,
                        vecs[i].ovf, vecs[i].dms, vecs[i].dsec);
        end

        $display("[TB] start button held for 100 cycles");
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, 1, 0, 0, i, 0);
            compareField("hold_ss", "state", int'(O_STATE), 1);
            compareField("hold_ss", "start_en", int'(O_START_EN), 1);
        end

        $display("[TB] lap freeze while timer advances");
        applyStimulus(0, 0, 1, 1, 250, 3);
        checkOutput("lap_enter", 2, 1, 0, 0, 250, 3);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 0, (i < 5), (i % 2 == 0), 250 + i * 7, 3);
            checkOutput("lap_hold", 2, 1, 0, 0, 250, 3);
        end
        applyStimulus(0, 0, 1, 0, 500, 4);
        checkOutput("lap_exit", 1, 1, 0, 0, 500, 4);
        applyStimulus(0, 0, 0, 0, 501, 4);
        checkOutput("lap_live", 1, 1, 0, 0, 501, 4);

        $display("[TB] randomized run against reference model");
        applyStimulus(1, 0, 0, 0, 0, 0);
        ss = 0; lc = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) ss = !ss;
            if ($urandom_range(5) == 0) lc = !lc;
            en  = ($urandom_range(3) == 0);
            rst = ($urandom_range(149) == 0);
            if ($urandom_range(9) == 0) begin
                ms = 999;
                sec = 59;
            end else begin
                ms = int'($urandom_range(999));
                sec = int'($urandom_range(59));
            end
            applyStimulus(rst, ss, lc, en, ms, sec);
            checkOutput("random", mState, int'(mStart), int'(mClear), int'(mOvf), mMs, mSec);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
